// File: rtl/apb_cmd_arbiter_if.sv
// Command/response bundle between requesters, the arbiter and the APB master.
// slave = arbiter side, master = requesters plus APB master top.
interface apb_cmd_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 9,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_rw;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic               transfer;
    logic               read_write;
    logic [AW-1:0]      apb_write_paddr;
    logic [DW-1:0]      apb_write_data;
    logic [AW-1:0]      apb_read_paddr;
    logic [DW-1:0]      apb_read_data_out;
    logic               xfer_done;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        input  apb_read_data_out, xfer_done,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output transfer, read_write,
        output apb_write_paddr, apb_write_data, apb_read_paddr
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        output apb_read_data_out, xfer_done,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  transfer, read_write,
        input  apb_write_paddr, apb_write_data, apb_read_paddr
    );
endinterface

// File: rtl/apb_cmd_arbiter.sv
// Round-robin arbiter sharing one APB master command port among NREQ requesters.
// One transaction in flight; aborts with an error flag after TIMEOUT busy cycles.
module apb_cmd_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 9,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input logic              pclk,
    input logic              preset,
    apb_cmd_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            rw_q, rw_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            transfer_q, transfer_d;
    logic            read_write_q, read_write_d;
    logic [AW-1:0]   wpaddr_q, wpaddr_d;
    logic [DW-1:0]   wdata_o_q, wdata_o_d;
    logic [AW-1:0]   rpaddr_q, rpaddr_d;

    logic            pick_ok;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    int              idx;
    logic            sel_rw;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    // First valid requester at or after rr_ptr, wrapping, and its command fields
    always_comb begin
        pick_ok   = 1'b0;
        pick      = '0;
        cand      = '0;
        idx       = 0;
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx  = (int'(rr_ptr_q) + i) % NREQ;
            cand = IW'(idx);
            if (!pick_ok && bus.req_valid[cand]) begin
                pick_ok = 1'b1;
                pick    = cand;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IW'(i)) begin
                sel_rw    = bus.req_rw[i];
                sel_addr  = bus.req_addr[i*AW +: AW];
                sel_wdata = bus.req_wdata[i*DW +: DW];
            end
        end
    end

    // Transaction sequencer: grant, drive master, wait done/timeout, respond
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;
        transfer_d   = transfer_q;
        read_write_d = read_write_q;
        wpaddr_d     = wpaddr_q;
        wdata_o_d    = wdata_o_q;
        rpaddr_d     = rpaddr_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_ok) begin
                    gnt_d              = pick;
                    rw_d               = sel_rw;
                    addr_d             = sel_addr;
                    wdata_d            = sel_wdata;
                    req_ready_d[pick]  = 1'b1;
                    state_d            = S_GRANT;
                end
            end
            S_GRANT: begin
                transfer_d   = 1'b1;
                read_write_d = rw_q;
                tmo_cnt_d    = '0;
                wpaddr_d     = rw_q ? addr_q : '0;
                wdata_o_d    = rw_q ? wdata_q : '0;
                rpaddr_d     = rw_q ? '0 : addr_q;
                state_d      = S_BUSY;
            end
            S_BUSY: begin
                if (bus.xfer_done || tmo_cnt_q == TMO_LAST) begin
                    // done takes priority over a coincident timeout
                    rsp_err_d          = !bus.xfer_done;
                    rsp_rdata_d        = (bus.xfer_done && !rw_q) ?
                                         bus.apb_read_data_out : '0;
                    rsp_valid_d[gnt_q] = 1'b1;
                    transfer_d         = 1'b0;
                    read_write_d       = 1'b0;
                    wpaddr_d           = '0;
                    wdata_o_d          = '0;
                    rpaddr_d           = '0;
                    state_d            = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            S_RESP: begin
                rr_ptr_d = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs, cleared immediately on reset
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            tmo_cnt_q    <= '0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            transfer_q   <= 1'b0;
            read_write_q <= 1'b0;
            wpaddr_q     <= '0;
            wdata_o_q    <= '0;
            rpaddr_q     <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            transfer_q   <= transfer_d;
            read_write_q <= read_write_d;
            wpaddr_q     <= wpaddr_d;
            wdata_o_q    <= wdata_o_d;
            rpaddr_q     <= rpaddr_d;
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_rdata       = rsp_rdata_q;
    assign bus.rsp_err         = rsp_err_q;
    assign bus.transfer        = transfer_q;
    assign bus.read_write      = read_write_q;
    assign bus.apb_write_paddr = wpaddr_q;
    assign bus.apb_write_data  = wdata_o_q;
    assign bus.apb_read_paddr  = rpaddr_q;
endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Scoreboard bench for apb_cmd_arbiter with a simple APB master responder.
// Expected responses are queued at stimulus time and popped on rsp_valid.
module tb_apb_cmd_arbiter;
    localparam int NREQ    = 2;
    localparam int AW      = 9;
    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    typedef struct {
        int             idx;
        logic           rw;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wd;
        logic [DW-1:0]  rd;
        logic           err;
    } exp_t;

    logic pclk;
    logic preset;
    apb_cmd_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    apb_cmd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    exp_t          sbq[$];
    int            nchk = 0;
    int            nerr = 0;
    int            done_dly = 2;
    logic [DW-1:0] rd_val = 8'h00;
    int            hi = 0;
    int            lo = 0;
    int            last_hi = 0;
    bit            started = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_req(input int i, input logic rw, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                            input logic er);
        exp_t e;
        e.idx = i; e.rw = rw; e.addr = a; e.wd = wd; e.rd = rd; e.err = er;
        sbq.push_back(e);
        bus.req_rw[i]              = rw;
        bus.req_addr[i*AW +: AW]   = a;
        bus.req_wdata[i*DW +: DW]  = wd;
        bus.req_valid[i]           = 1'b1;
    endtask

    // one clock: APB responder, grant monitor and response scoreboard
    task automatic step();
        exp_t e;
        @(negedge pclk);
        bus.xfer_done         = 1'b0;
        bus.apb_read_data_out = 8'hEE;
        if (bus.transfer) begin
            if (hi == 0 && started) chk("idle_gap", 32'(lo >= 1), 1);
            hi++;
            lo = 0;
            started = 1;
            if (hi == 1 && sbq.size() > 0) begin
                e = sbq[0];
                chk("read_write", bus.read_write, e.rw);
                chk("wr_paddr", bus.apb_write_paddr, e.rw ? e.addr : 0);
                chk("wr_data", bus.apb_write_data, e.rw ? e.wd : 0);
                chk("rd_paddr", bus.apb_read_paddr, e.rw ? 0 : e.addr);
            end
            if (hi == done_dly) begin
                bus.xfer_done         = 1'b1;
                bus.apb_read_data_out = rd_val;
            end
        end else begin
            if (hi != 0) last_hi = hi;
            hi = 0;
            lo++;
        end
        if (bus.req_ready != '0) begin
            if (sbq.size() == 0) chk("grant_unexp", bus.req_ready, 0);
            else chk("grant", bus.req_ready, 32'(1) << sbq[0].idx);
            for (int i = 0; i < NREQ; i++)
                if (bus.req_ready[i]) bus.req_addr[i*AW +: AW] = 9'h1FF;
            bus.req_valid = bus.req_valid & ~bus.req_ready;
        end
        if (bus.rsp_valid != '0) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexp", bus.rsp_valid, 0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_valid", bus.rsp_valid, 32'(1) << e.idx);
                chk("rsp_rdata", bus.rsp_rdata, e.rd);
                chk("rsp_err", bus.rsp_err, e.err);
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sbq.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (sbq.size() > 0) begin
            chk("wait_budget", 0, 1);
            sbq.delete();
            bus.req_valid = '0;
        end
        step();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_transfer"}, bus.transfer, 0);
        chk({tag, "_rw"}, bus.read_write, 0);
        chk({tag, "_wpaddr"}, bus.apb_write_paddr, 0);
        chk({tag, "_wdata"}, bus.apb_write_data, 0);
        chk({tag, "_rpaddr"}, bus.apb_read_paddr, 0);
        chk({tag, "_rdy"}, bus.req_ready, 0);
        chk({tag, "_rspv"}, bus.rsp_valid, 0);
        chk({tag, "_rsp"}, {bus.rsp_err, bus.rsp_rdata}, 0);
    endtask

    initial begin
        preset                = 1'b1;
        bus.req_valid         = '0;
        bus.req_rw            = '0;
        bus.req_addr          = '0;
        bus.req_wdata         = '0;
        bus.xfer_done         = 1'b0;
        bus.apb_read_data_out = '0;

        // contention from reset: req0 then req1, twice
        done_dly = 2;
        rd_val   = 8'h5A;
        push_req(0, 1'b1, 9'h0A1, 8'h11, 8'h00, 1'b0);
        push_req(1, 1'b0, 9'h1F0, 8'h22, 8'h5A, 1'b0);
        step();
        step();
        chk_zero("rst");
        preset = 1'b0;
        wait_done(100);
        push_req(0, 1'b0, 9'h044, 8'h33, 8'h5A, 1'b0);
        push_req(1, 1'b1, 9'h155, 8'h44, 8'h00, 1'b0);
        wait_done(100);

        // single write
        done_dly = 3;
        rd_val   = 8'h99;
        push_req(0, 1'b1, 9'h105, 8'hA5, 8'h00, 1'b0);
        wait_done(100);
        chk("wr_len", last_hi, 3);

        // read from req1
        rd_val = 8'h3C;
        push_req(1, 1'b0, 9'h012, 8'h00, 8'h3C, 1'b0);
        wait_done(100);

        // timeout, then normal service
        done_dly = -1;
        push_req(0, 1'b0, 9'h033, 8'h00, 8'h00, 1'b1);
        wait_done(100);
        chk("tmo_len", last_hi, TIMEOUT);
        done_dly = 1;
        rd_val   = 8'h81;
        push_req(1, 1'b1, 9'h0F0, 8'h5C, 8'h00, 1'b0);
        wait_done(100);

        // done coincides with timeout
        done_dly = TIMEOUT;
        rd_val   = 8'h77;
        push_req(0, 1'b0, 9'h1AB, 8'h00, 8'h77, 1'b0);
        wait_done(100);
        chk("late_len", last_hi, TIMEOUT);

        // reset in the middle of a busy transaction from req1
        done_dly = -1;
        push_req(1, 1'b0, 9'h0C3, 8'h00, 8'h00, 1'b0);
        for (int n = 0; n < 20 && !bus.transfer; n++) step();
        chk("mid_busy", bus.transfer, 1);
        step();
        step();
        preset = 1'b1;
        #1;
        chk_zero("async_rst");
        sbq.delete();
        bus.req_valid = '0;
        hi      = 0;
        lo      = 0;
        started = 0;
        done_dly = 2;
        rd_val   = 8'h6E;
        push_req(0, 1'b1, 9'h011, 8'h0F, 8'h00, 1'b0);
        push_req(1, 1'b0, 9'h022, 8'h00, 8'h6E, 1'b0);
        step();
        step();
        preset = 1'b0;
        step();
        chk("rel_grant", bus.req_ready, 1);
        wait_done(100);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
